// File: rtl/booth_seq_pkg.sv
// Shared types and defaults for the Booth multiplier operand sequencer.
package booth_seq_pkg;
  typedef enum logic [2:0] {IDLE, START, LDM, LDQ, WAIT, RESP} seq_state_t;

  localparam int DW_DEF      = 16;
  localparam int TIMEOUT_DEF = 64;

  // Counter width that can hold the value TIMEOUT itself.
  function automatic int cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction
endpackage

// File: rtl/booth_seq_timer.sv
// Clear/enable watchdog counter; tc is high once the count reaches LIMIT.
module booth_seq_timer #(
  parameter int W     = 7,
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [W-1:0] cnt;

  assign tc = (cnt == W'(LIMIT));

  // Saturates at LIMIT so a late abort can never wrap back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cnt <= '0;
    else if (clr)       cnt <= '0;
    else if (en && !tc) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/booth_seq_frontend.sv
// Operand sequencer: serial-loads M then Q into the Booth multiplier,
// waits for done (with watchdog) and returns the result on a valid/ready channel.
module booth_seq_frontend
  import booth_seq_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  output logic          mul_start,
  output logic [DW-1:0] mul_data,
  input  logic          mul_done,
  input  logic [DW-1:0] mul_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          res_err,
  output logic          busy,
  output logic [15:0]   op_count
);
  localparam int CW = cnt_w(TIMEOUT);

  seq_state_t    state, nxt;
  logic [DW-1:0] op_a, op_b;
  logic          armed, alive, tmo, accept, hit;

  booth_seq_timer #(.W(CW), .LIMIT(TIMEOUT)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state == LDQ),
    .en   (state == WAIT),
    .tc   (tmo)
  );

  // alive keeps in_ready low while reset is held.
  assign in_ready  = alive && (state == IDLE);
  assign accept    = in_ready && in_valid;
  assign hit       = armed && mul_done;
  assign mul_start = (state == START);
  assign res_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_comb begin
    nxt      = state;
    mul_data = '0;
    case (state)
      IDLE:  if (accept) nxt = START;
      START: begin mul_data = op_a; nxt = LDM; end
      LDM:   begin mul_data = op_a; nxt = LDQ; end
      LDQ:   begin mul_data = op_b; nxt = WAIT; end
      WAIT: begin
        mul_data = op_b;
        if (hit || tmo) nxt = RESP;
      end
      RESP:  if (res_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      alive    <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      armed    <= 1'b0;
      res_data <= '0;
      res_err  <= 1'b0;
      op_count <= '0;
    end else begin
      state <= nxt;
      alive <= 1'b1;
      if (accept) begin
        op_a <= in_a;
        op_b <= in_b;
      end
      // A done level still high from the previous op is ignored until it drops.
      if (state == LDQ)                    armed <= 1'b0;
      else if (state == WAIT && !mul_done) armed <= 1'b1;
      if (state == WAIT) begin
        if (hit) begin
          res_data <= mul_out;
          res_err  <= 1'b0;
        end else if (tmo) begin
          res_data <= '0;
          res_err  <= 1'b1;
        end
      end
      if (state == RESP && res_ready) op_count <= op_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_booth_seq_frontend.sv
// Directed bench for booth_seq_frontend with a behavioural multiplier model.
module tb_booth_seq_frontend;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0, in_b = '0;
  logic        mul_start;
  logic [15:0] mul_data;
  logic        mul_done;
  logic [15:0] mul_out;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic        res_err;
  logic        busy;
  logic [15:0] op_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_seq_frontend #(.DW(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_start(mul_start), .mul_data(mul_data),
    .mul_done(mul_done), .mul_out(mul_out), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .busy(busy), .op_count(op_count)
  );

  // Multiplier model: mcyc=1 in LDM, 2 in LDQ; done from mcyc 10 (8 after LDQ).
  // mode 0 normal, 1 done stays high through WAIT cycle 1, 2 never done.
  int          mode = 0;
  int          mcyc = 0;
  logic [15:0] m_reg = '0, q_reg = '0, p_reg = '0;

  always @(posedge clk) begin
    if (mul_start) mcyc <= 1;
    else if (mcyc != 0 && mcyc < 20) mcyc <= mcyc + 1;
    if (mcyc == 1) m_reg <= mul_data;
    if (mcyc == 2) q_reg <= mul_data;
    if (mcyc == 9) p_reg <= m_reg * q_reg;
  end

  assign mul_done = (mode == 0) ? (mcyc >= 10) :
                    (mode == 1) ? (mcyc <= 4 || mcyc >= 10) : 1'b0;
  assign mul_out  = p_reg;

  // Issues a pair, checks the three load cycles; returns at the LDQ negedge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!in_ready) begin errors++; $display("FAIL in_ready_wait got 0 want 1"); end
    in_valid = 1'b1; in_a = a; in_b = b;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mul_start !== 1'b1 || mul_data !== a) begin
      errors++; $display("FAIL start_cycle got start=%b data=%h want 1 %h", mul_start, mul_data, a);
    end
    @(negedge clk);
    checks++;
    if (mul_start !== 1'b0 || mul_data !== a) begin
      errors++; $display("FAIL ldm_cycle got start=%b data=%h want 0 %h", mul_start, mul_data, a);
    end
    @(negedge clk);
    checks++;
    if (mul_data !== b) begin errors++; $display("FAIL ldq_cycle got %h want %h", mul_data, b); end
  endtask

  // Waits for res_valid; n = negedges elapsed since the LDQ negedge.
  task automatic wait_res(output int n);
    n = 0;
    while (!res_valid && n < 40) begin @(negedge clk); n++; end
  endtask

  task automatic retire();
    res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    checks++;
    if ({in_ready, mul_start, res_valid, res_err, busy} !== 5'b0 ||
        mul_data !== 16'h0 || res_data !== 16'h0 || op_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b st=%b v=%b e=%b busy=%b md=%h rd=%h cnt=%h want all 0",
               in_ready, mul_start, res_valid, res_err, busy, mul_data, res_data, op_count);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL ready_after_reset got rdy=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_mult();
    logic [15:0] va [3] = '{16'h0003, 16'hFFFE, 16'h8000};
    logic [15:0] vb [3] = '{16'h0005, 16'h0007, 16'hFFFF};
    logic [15:0] vp [3] = '{16'h000F, 16'hFFF2, 16'h8000};
    int n;
    mode = 0;
    for (int i = 0; i < 3; i++) begin
      issue(va[i], vb[i]);
      wait_res(n);
      checks++;
      if (n !== 9) begin errors++; $display("FAIL mult%0d_latency got %0d want 9", i, n); end
      checks++;
      if (res_valid !== 1'b1 || res_data !== vp[i] || res_err !== 1'b0) begin
        errors++; $display("FAIL mult%0d_result got v=%b d=%h e=%b want 1 %h 0",
                           i, res_valid, res_data, res_err, vp[i]);
      end
      retire();
      checks++;
      if (op_count !== 16'(i + 1) || res_valid !== 1'b0) begin
        errors++; $display("FAIL mult%0d_count got %0d v=%b want %0d 0", i, op_count, res_valid, i + 1);
      end
    end
  endtask

  task automatic test_stale_done();
    int n;
    mode = 1;
    checks++;
    if (mul_done !== 1'b1) begin errors++; $display("FAIL stale_setup got done=%b want 1", mul_done); end
    issue(16'h0004, 16'h0004);
    wait_res(n);
    checks++;
    if (n !== 9) begin errors++; $display("FAIL stale_latency got %0d want 9", n); end
    checks++;
    if (res_data !== 16'h0010 || res_err !== 1'b0) begin
      errors++; $display("FAIL stale_result got d=%h e=%b want 0010 0", res_data, res_err);
    end
    retire();
    checks++;
    if (op_count !== 16'd4) begin errors++; $display("FAIL stale_count got %0d want 4", op_count); end
  endtask

  task automatic test_timeout();
    int n;
    mode = 2;
    issue(16'h0001, 16'h0001);
    wait_res(n);
    // WAIT entry is one cycle after LDQ; res_valid 9 cycles after that.
    checks++;
    if (n !== 10) begin errors++; $display("FAIL timeout_latency got %0d want 10", n); end
    checks++;
    if (res_valid !== 1'b1 || res_err !== 1'b1 || res_data !== 16'h0) begin
      errors++; $display("FAIL timeout_result got v=%b e=%b d=%h want 1 1 0000", res_valid, res_err, res_data);
    end
    retire();
    checks++;
    if (op_count !== 16'd5) begin errors++; $display("FAIL timeout_count got %0d want 5", op_count); end
  endtask

  task automatic test_hold();
    int n;
    mode = 0;
    issue(16'h0006, 16'h0007);
    wait_res(n);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin in_valid = 1'b1; in_a = 16'h1111; in_b = 16'h2222; end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (res_valid !== 1'b1 || res_data !== 16'h002A || res_err !== 1'b0 || in_ready !== 1'b0) begin
        errors++; $display("FAIL hold_c%0d got v=%b d=%h e=%b rdy=%b want 1 002a 0 0",
                           c, res_valid, res_data, res_err, in_ready);
      end
    end
    retire();
    checks++;
    if (op_count !== 16'd6 || busy !== 1'b0 || mul_start !== 1'b0) begin
      errors++; $display("FAIL hold_release got cnt=%0d busy=%b st=%b want 6 0 0", op_count, busy, mul_start);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL hold_no_accept got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int n;
    mode = 0;
    issue(16'h0003, 16'h0003);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, mul_start, res_valid, res_err, busy} !== 5'b0 ||
        mul_data !== 16'h0 || res_data !== 16'h0 || op_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid got rdy=%b st=%b v=%b e=%b busy=%b md=%h rd=%h cnt=%h want all 0",
               in_ready, mul_start, res_valid, res_err, busy, mul_data, res_data, op_count);
    end
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    issue(16'h0002, 16'h0009);
    wait_res(n);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 16'h0012 || res_err !== 1'b0) begin
      errors++; $display("FAIL post_reset_result got v=%b d=%h e=%b want 1 0012 0", res_valid, res_data, res_err);
    end
    retire();
    checks++;
    if (op_count !== 16'd1) begin errors++; $display("FAIL post_reset_count got %0d want 1", op_count); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_stale_done();
    test_timeout();
    test_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
